pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_slot.sv | 37 +++
 rtl/pipe_chain.sv | 131 +++++++++++++
 tb/tb_pipe_chain.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipe_chain stage registers: slot contents, per-slot
// operation select and the default bubble payload.
package pipe_pkg;

    localparam int          SLOT_DATA_W      = 64;
    localparam logic [63:0] NOP_DATA_DEFAULT = 64'h13;

    typedef enum logic [1:0] {
        ADVANCE,
        HOLD,
        BUBBLE
    } slot_op_e;

    typedef struct packed {
        logic                   valid;
        logic                   halt;
        logic [SLOT_DATA_W-1:0] data;
    } slot_t;

    function automatic slot_t bubble_slot(input logic [SLOT_DATA_W-1:0] nop);
        slot_t b;
        b.valid = 1'b0;
        b.halt  = 1'b0;
        b.data  = nop;
        return b;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline stage register: loads the previous stage, holds, or loads a
// bubble according to the op chosen by the chain controller.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter logic [SLOT_DATA_W-1:0] NOP_DATA = NOP_DATA_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    input  slot_op_e op,
    input  slot_t    prev,
    output slot_t    cur
);

    slot_t slot_d;
    slot_t slot_q;

    always_comb begin
        slot_d = slot_q;
        case (op)
            ADVANCE: slot_d = prev;
            HOLD:    slot_d = slot_q;
            default: slot_d = bubble_slot(NOP_DATA);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= bubble_slot(NOP_DATA);
        end else begin
            slot_q <= slot_d;
        end
    end

    assign cur = slot_q;

endmodule

// File: rtl/pipe_chain.sv
// In-order pipeline of STAGES registers with stall (hold + bubble), flush
// (kill younger stages), halt-marker tracking and a bubble counter.
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int          STAGES   = 4,
    parameter int          WIDTH    = 64,
    parameter logic [63:0] NOP_DATA = NOP_DATA_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_halt,
    output logic                        in_ready,
    input  logic                        stall,
    input  logic [$clog2(STAGES)-1:0]   stall_idx,
    input  logic                        flush,
    input  logic [$clog2(STAGES)-1:0]   flush_idx,
    output logic [STAGES-1:0]           stg_valid,
    output logic [STAGES*WIDTH-1:0]     stg_data,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_halt,
    output logic                        halted,
    output logic [15:0]                 bubble_cnt
);

    localparam int                     IDX_W    = $clog2(STAGES);
    localparam logic [IDX_W-1:0]       K_MAX    = IDX_W'(STAGES - 2);
    localparam logic [SLOT_DATA_W-1:0] NOP_SLOT = SLOT_DATA_W'(NOP_DATA[WIDTH-1:0]);

    logic [IDX_W-1:0] stall_k;
    logic [IDX_W-1:0] flush_k;
    logic             accept;
    logic             kill_halt;
    slot_t            in_slot;
    slot_t            last_next;
    slot_op_e         slot_op   [STAGES];
    slot_t            slot_prev [STAGES];
    slot_t            slot_cur  [STAGES];

    logic        halt_seen_d, halt_seen_q;
    logic        halted_d, halted_q;
    logic [15:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        stall_k  = (stall_idx > K_MAX) ? K_MAX : stall_idx;
        flush_k  = (flush_idx > K_MAX) ? K_MAX : flush_idx;
        in_ready = !rst && !stall && !flush && !halt_seen_q;
        accept   = in_valid && in_ready;

        // Once a halt marker is in flight, stage 0 only ever sees bubbles.
        in_slot = bubble_slot(NOP_SLOT);
        if (!halt_seen_q) begin
            in_slot.valid = accept;
            in_slot.halt  = in_halt && accept;
            in_slot.data  = SLOT_DATA_W'(in_data);
        end

        slot_prev[0] = in_slot;
        for (int s = 1; s < STAGES; s++) begin
            slot_prev[s] = slot_cur[s-1];
        end

        kill_halt = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            if (flush) begin
                slot_op[s] = (s <= int'(flush_k)) ? BUBBLE : ADVANCE;
                if (s <= int'(flush_k) && slot_cur[s].valid && slot_cur[s].halt) begin
                    kill_halt = 1'b1;
                end
            end else if (stall) begin
                if (s <= int'(stall_k)) begin
                    slot_op[s] = HOLD;
                end else if (s == int'(stall_k) + 1) begin
                    slot_op[s] = BUBBLE;
                end else begin
                    slot_op[s] = ADVANCE;
                end
            end else begin
                slot_op[s] = ADVANCE;
            end
        end

        // The final stage is never held, so its next value is advance or bubble.
        last_next = (slot_op[STAGES-1] == ADVANCE) ? slot_cur[STAGES-2] : bubble_slot(NOP_SLOT);

        halt_seen_d = (halt_seen_q && !kill_halt) || (accept && in_halt);
        halted_d    = halted_q || (last_next.valid && last_next.halt);

        bubble_cnt_d = bubble_cnt_q;
        if ((stall || flush) && bubble_cnt_q != 16'hFFFF) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_seen_q  <= 1'b0;
            halted_q     <= 1'b0;
            bubble_cnt_q <= 16'd0;
        end else begin
            halt_seen_q  <= halt_seen_d;
            halted_q     <= halted_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        pipe_slot #(
            .NOP_DATA (NOP_SLOT)
        ) u_slot (
            .clk  (clk),
            .rst  (rst),
            .op   (slot_op[g]),
            .prev (slot_prev[g]),
            .cur  (slot_cur[g])
        );

        assign stg_valid[g]                = slot_cur[g].valid;
        assign stg_data[g*WIDTH +: WIDTH]  = slot_cur[g].data[WIDTH-1:0];
    end

    assign out_valid  = slot_cur[STAGES-1].valid;
    assign out_data   = slot_cur[STAGES-1].data[WIDTH-1:0];
    assign out_halt   = slot_cur[STAGES-1].halt;
    assign halted     = halted_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Bench for pipe_chain (STAGES=4, WIDTH=64): list-level reference model with a
// per-cycle compare, plus directed scenarios with literal expectations.
module tb_pipe_chain;

    localparam logic [63:0] NOP = 64'h13;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [63:0]  in_data = NOP;
    logic         in_halt = 1'b0;
    logic         in_ready;
    logic         stall = 1'b0;
    logic [1:0]   stall_idx = 2'd0;
    logic         flush = 1'b0;
    logic [1:0]   flush_idx = 2'd0;
    logic [3:0]   stg_valid;
    logic [255:0] stg_data;
    logic         out_valid;
    logic [63:0]  out_data;
    logic         out_halt;
    logic         halted;
    logic [15:0]  bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_chain #(
        .STAGES   (4),
        .WIDTH    (64),
        .NOP_DATA (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_halt    (in_halt),
        .in_ready   (in_ready),
        .stall      (stall),
        .stall_idx  (stall_idx),
        .flush      (flush),
        .flush_idx  (flush_idx),
        .stg_valid  (stg_valid),
        .stg_data   (stg_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_halt   (out_halt),
        .halted     (halted),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the pipeline as a list of four entries, youngest first.
    typedef struct {
        bit          valid;
        bit          halt;
        logic [63:0] data;
    } mslot_t;

    mslot_t m [4];
    mslot_t nx [4];
    bit     m_hs = 1'b0;
    bit     m_halted = 1'b0;
    int     m_cnt = 0;
    bit     started = 1'b0;

    function automatic mslot_t bub();
        mslot_t b;
        b.valid = 1'b0;
        b.halt  = 1'b0;
        b.data  = NOP;
        return b;
    endfunction

    function automatic bit model_ready();
        return !rst && !stall && !flush && !m_hs;
    endfunction

    always @(posedge clk) begin
        bit     acc;
        int     k;
        mslot_t src;
        started = 1'b1;
        if (rst) begin
            for (int s = 0; s < 4; s++) m[s] = bub();
            m_hs = 1'b0;
            m_halted = 1'b0;
            m_cnt = 0;
        end else begin
            acc = in_valid && model_ready();
            if (flush) begin
                k = (int'(flush_idx) > 2) ? 2 : int'(flush_idx);
                for (int s = 0; s < 4; s++) begin
                    if (s <= k) begin
                        if (m[s].valid && m[s].halt) m_hs = 1'b0;
                        nx[s] = bub();
                    end else begin
                        nx[s] = m[s-1];
                    end
                end
            end else if (stall) begin
                k = (int'(stall_idx) > 2) ? 2 : int'(stall_idx);
                for (int s = 0; s < 4; s++) begin
                    if (s <= k)          nx[s] = m[s];
                    else if (s == k + 1) nx[s] = bub();
                    else                 nx[s] = m[s-1];
                end
            end else begin
                if (m_hs) begin
                    src = bub();
                end else begin
                    src.valid = acc;
                    src.halt  = in_halt && acc;
                    src.data  = in_data;
                end
                nx[0] = src;
                for (int s = 1; s < 4; s++) nx[s] = m[s-1];
            end
            if (acc && in_halt) m_hs = 1'b1;
            if (stall || flush) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            for (int s = 0; s < 4; s++) m[s] = nx[s];
            if (m[3].valid && m[3].halt) m_halted = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [3:0]   ev;
        logic [255:0] ed;
        if (started) begin
            for (int s = 0; s < 4; s++) begin
                ev[s] = m[s].valid;
                ed[s*64 +: 64] = m[s].data;
            end
            chk("stg_valid", 256'(stg_valid), 256'(ev));
            chk("stg_data", stg_data, ed);
            chk("out_valid", 256'(out_valid), 256'(m[3].valid));
            chk("out_data", 256'(out_data), 256'(m[3].data));
            chk("out_halt", 256'(out_halt), 256'(m[3].halt));
            chk("halted", 256'(halted), 256'(m_halted));
            chk("bubble_cnt", 256'(bubble_cnt), 256'(m_cnt));
            chk("in_ready", 256'(in_ready), 256'(model_ready()));
        end
    end

    task automatic set_in(input bit v, input logic [63:0] d, input bit h,
                          input bit st, input logic [1:0] si, input bit fl, input logic [1:0] fi);
        in_valid  = v;
        in_data   = d;
        in_halt   = h;
        stall     = st;
        stall_idx = si;
        flush     = fl;
        flush_idx = fi;
    endtask

    task automatic cyc(input bit v, input logic [63:0] d, input bit h,
                       input bit st, input logic [1:0] si, input bit fl, input logic [1:0] fi);
        set_in(v, d, h, st, si, fl, fi);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, NOP, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic push(input logic [63:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    initial begin
        // Reset values
        idle(2);
        chk("rst_stg_valid", 256'(stg_valid), 256'(0));
        chk("rst_stg_data", stg_data, {4{NOP}});
        chk("rst_bubble_cnt", 256'(bubble_cnt), 256'(0));
        chk("rst_halted", 256'(halted), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 256'(in_ready), 256'(1));

        // Plain stream A1..A6
        for (int i = 1; i <= 6; i++) begin
            push(64'hA000_0000_0000_0000 | 64'(i));
            if (i == 4) chk("stream_a1_out", 256'(out_data), 256'(64'hA000_0000_0000_0001));
            if (i == 5) chk("stream_a2_out", 256'(out_data), 256'(64'hA000_0000_0000_0002));
        end
        idle(4);
        chk("stream_bubbles", 256'(bubble_cnt), 256'(0));

        // Stall idx 1 with A,B,C in stages 0,1,2
        push(64'hC);
        push(64'hB);
        push(64'hA);
        cyc(1'b1, 64'hD, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0);
        chk("stall_s0", 256'(stg_data[63:0]), 256'(64'hA));
        chk("stall_s1", 256'(stg_data[127:64]), 256'(64'hB));
        chk("stall_s2_valid", 256'(stg_valid[2]), 256'(0));
        chk("stall_s2_data", 256'(stg_data[191:128]), 256'(NOP));
        chk("stall_out_c", 256'(out_data), 256'(64'hC));
        cyc(1'b1, 64'hD, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0);
        chk("stall_s2_valid2", 256'(stg_valid[2]), 256'(0));
        chk("stall_in_ready", 256'(in_ready), 256'(0));
        chk("stall_bubbles", 256'(bubble_cnt), 256'(2));
        idle(4);

        // Flush idx 1 with X,Y,Z in stages 0,1,2
        push(64'h2);
        push(64'h1);
        push(64'h0);
        cyc(1'b1, 64'h77, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1);
        chk("flush_s01_valid", 256'(stg_valid[1:0]), 256'(0));
        chk("flush_s2", 256'(stg_data[191:128]), 256'(64'h1));
        chk("flush_s3", 256'(out_data), 256'(64'h2));
        chk("flush_bubbles", 256'(bubble_cnt), 256'(3));
        idle(4);

        // Stall and flush together: flush wins
        push(64'h52);
        push(64'h51);
        push(64'h50);
        cyc(1'b1, 64'h99, 1'b0, 1'b1, 2'd2, 1'b1, 2'd0);
        chk("both_s0_valid", 256'(stg_valid[0]), 256'(0));
        chk("both_s1", 256'(stg_data[127:64]), 256'(64'h50));
        chk("both_s2", 256'(stg_data[191:128]), 256'(64'h51));
        chk("both_s3", 256'(out_data), 256'(64'h52));
        chk("both_bubbles", 256'(bubble_cnt), 256'(4));
        idle(4);

        // Indices above STAGES-2 clamp to 2
        push(64'hE3);
        push(64'hE2);
        push(64'hE1);
        cyc(1'b0, NOP, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0);
        chk("clamp_stall_out", 256'(out_valid), 256'(0));
        chk("clamp_stall_s2", 256'(stg_data[191:128]), 256'(64'hE3));
        cyc(1'b0, NOP, 1'b0, 1'b0, 2'd0, 1'b1, 2'd3);
        chk("clamp_flush_valid", 256'(stg_valid), 256'(4'b1000));
        chk("clamp_flush_out", 256'(out_data), 256'(64'hE3));
        chk("clamp_bubbles", 256'(bubble_cnt), 256'(6));
        idle(4);

        // Halt marker reaches the final stage and sticks
        cyc(1'b1, 64'hF00D, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("halt_in_ready", 256'(in_ready), 256'(0));
        push(64'h123);
        push(64'h123);
        push(64'h123);
        chk("halt_out_data", 256'(out_data), 256'(64'hF00D));
        chk("halt_out_halt", 256'(out_halt), 256'(1));
        chk("halt_halted", 256'(halted), 256'(1));
        idle(2);
        chk("halt_sticky", 256'(halted), 256'(1));
        chk("halt_drained", 256'(stg_valid), 256'(0));

        // Reset, then a flush kills the pending halt marker
        rst = 1'b1;
        idle(1);
        chk("rst2_halted", 256'(halted), 256'(0));
        rst = 1'b0;
        cyc(1'b1, 64'hBEEF, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        cyc(1'b0, NOP, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1);
        chk("kill_valid", 256'(stg_valid), 256'(0));
        chk("kill_halted", 256'(halted), 256'(0));
        set_in(1'b0, NOP, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        #1;
        chk("kill_in_ready", 256'(in_ready), 256'(1));
        push(64'hF1);
        chk("kill_accept", 256'(stg_data[63:0]), 256'(64'hF1));
        idle(4);
        chk("kill_halted_end", 256'(halted), 256'(0));

        // Reset in the middle of a stall
        push(64'h61);
        push(64'h62);
        rst = 1'b1;
        cyc(1'b1, 64'h63, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0);
        chk("rst_mid_valid", 256'(stg_valid), 256'(0));
        chk("rst_mid_data", stg_data, {4{NOP}});
        chk("rst_mid_bubbles", 256'(bubble_cnt), 256'(0));
        chk("rst_mid_in_ready", 256'(in_ready), 256'(0));
        rst = 1'b0;

        // Bubble counter saturation
        for (int i = 0; i < 65540; i++) cyc(1'b0, NOP, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
        chk("sat_bubbles", 256'(bubble_cnt), 256'(16'hFFFF));
        cyc(1'b0, NOP, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0);
        chk("sat_hold", 256'(bubble_cnt), 256'(16'hFFFF));
        idle(2);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
